// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// Contents: the FSM state enum, the request size encodings and the word geometry.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_e;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    localparam int BYTES_PER_WORD = 2;

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the core request/response handshakes and the data-memory port.
// Modports:
//   slave  - the load/store unit. It consumes requests, produces responses and
//            drives the memory.
//   master - the core plus memory side. It is the mirror image of slave.
interface load_store_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_data, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_data, mem_write
    );
endinterface

// File: rtl/load_store_unit_byte_lane.sv
// Combinational byte-lane logic for 16-bit little-endian words.
// Ports:
//   lane      - in  : byte select (0 = [7:0], 1 = [15:8])
//   size      - in  : SIZE_WORD or SIZE_BYTE
//   is_signed - in  : sign-extend a byte load
//   rdata     - in  : word read from memory
//   wbyte     - in  : byte to insert on a store
//   load_data - out : whole word, or the selected byte after extension
//   merged    - out : rdata with the selected byte replaced by wbyte
module lsu_byte_lane
    import load_store_unit_pkg::*;
(
    input  logic        lane,
    input  logic        size,
    input  logic        is_signed,
    input  logic [15:0] rdata,
    input  logic [7:0]  wbyte,
    output logic [15:0] load_data,
    output logic [15:0] merged
);
    logic [7:0] byte_s;

    // Load-path extract/extend and store-path merge
    always_comb begin
        byte_s    = lane ? rdata[15:8] : rdata[7:0];
        load_data = rdata;
        merged    = rdata;
        if (size == SIZE_BYTE) begin
            load_data = {{8{is_signed & byte_s[7]}}, byte_s};
        end else begin
            load_data = rdata;
        end
        if (lane) begin
            merged = {wbyte, rdata[7:0]};
        end else begin
            merged = {rdata[15:8], wbyte};
        end
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit. It sits on the initiator side of the word-addressed data memory.
// It takes one request at a time from the core and checks it for alignment and
// range. It then performs a word access, a byte load with extension, or a byte
// store using read-modify-write. It returns exactly one response per request.
// Ports:
//   clk, rst - clock, and a synchronous active-high reset
//   bus      - slave modport carrying:
//              req_*  (request handshake)
//              resp_* (response handshake)
//              mem_*  (memory port)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    lsu_state_e        state_r, state_next_s;
    logic              write_r, size_r, signed_r, lane_r;
    logic [7:0]        wbyte_r;
    logic [ADDR_W-1:0] mem_address_r;
    logic [DATA_W-1:0] mem_write_data_r, resp_rdata_r;
    logic              resp_err_r;

    logic              accept_s, err_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [DATA_W-1:0] load_data_s, merged_s;

    assign accept_s    = bus.req_valid & bus.req_ready;
    assign word_addr_s = {1'b0, bus.req_addr[ADDR_W-1:1]};
    assign err_s       = ((bus.req_size == SIZE_WORD) & bus.req_addr[0])
                       | (word_addr_s >= ADDR_W'(DEPTH));

    assign bus.req_ready      = (state_r == ST_IDLE);
    assign bus.resp_valid     = (state_r == ST_RESP);
    // The write strobe is a decode of state so that a write already in
    // progress still lands on the same edge as a reset.
    assign bus.mem_write      = (state_r == ST_WRITE);
    assign bus.mem_address    = mem_address_r;
    assign bus.mem_write_data = mem_write_data_r;
    assign bus.resp_rdata     = resp_rdata_r;
    assign bus.resp_err       = resp_err_r;

    lsu_byte_lane u_byte_lane (
        .lane      (lane_r),
        .size      (size_r),
        .is_signed (signed_r),
        .rdata     (bus.mem_read_data),
        .wbyte     (wbyte_r),
        .load_data (load_data_s),
        .merged    (merged_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_next_s = ST_IDLE;
                end else if (err_s) begin
                    state_next_s = ST_RESP;
                end else if (!bus.req_write) begin
                    state_next_s = ST_READ;
                end else if (bus.req_size == SIZE_WORD) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_RMW_READ;
                end
            end
            ST_READ:     state_next_s = ST_RESP;
            ST_RMW_READ: state_next_s = ST_WRITE;
            ST_WRITE:    state_next_s = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default:     state_next_s = ST_IDLE;
        endcase
    end

    // Request latch, memory address/data and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            write_r          <= 1'b0;
            size_r           <= SIZE_WORD;
            signed_r         <= 1'b0;
            lane_r           <= 1'b0;
            wbyte_r          <= 8'h00;
            mem_address_r    <= '0;
            mem_write_data_r <= '0;
            resp_rdata_r     <= '0;
            resp_err_r       <= 1'b0;
        end else if (accept_s) begin
            write_r       <= bus.req_write;
            size_r        <= bus.req_size;
            signed_r      <= bus.req_signed;
            lane_r        <= bus.req_addr[0];
            wbyte_r       <= bus.req_wdata[7:0];
            mem_address_r <= word_addr_s;
            // Stores and errors return zero data, so clear it up front.
            resp_rdata_r  <= '0;
            resp_err_r    <= err_s;
            if (bus.req_write && (bus.req_size == SIZE_WORD)) begin
                mem_write_data_r <= bus.req_wdata;
            end
        end else if (state_r == ST_READ) begin
            resp_rdata_r <= load_data_s;
        end else if (state_r == ST_RMW_READ) begin
            mem_write_data_r <= merged_s;
        end
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port.
- Accepts load/store requests from the core pipeline over a valid/ready handshake and drives the word-addressed data memory: address, write_data, mem_write, and asynchronous read_data back.
- Adds byte-granular access: byte stores via read-modify-write, byte loads with sign/zero extension.
- Adds alignment and range checking, and returns one response per request over a second valid/ready handshake.

Parameters:
- ADDR_W, 16, width of the core byte address and of mem_address
- DATA_W, 16, data word width (fixed at 16; byte lanes assume 2 bytes per word)
- DEPTH, 1024, number of valid memory words; word addresses >= DEPTH are errors

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  1  0=word, 1=byte
- req_signed  in  1  byte load: 1=sign-extend, 0=zero-extend; ignored otherwise
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data (byte store uses bits [7:0])
- resp_valid  out  1  response present
- resp_ready  in  1  core accepts response
- resp_rdata  out  DATA_W  load result; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range request
- mem_address  out  ADDR_W  word address to memory
- mem_write_data  out  DATA_W  write data to memory
- mem_write  out  1  memory write enable
- mem_read_data  in  DATA_W  asynchronous read data from memory

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_address 0, mem_write_data 0, mem_write 0.
- Word address = {1'b0, addr[15:1]}. Byte lane select = addr[0], little-endian: 0 selects [7:0], 1 selects [15:8].
- Request accept: on req_valid & req_ready, latch write, size, signed, addr and wdata.
- Request classification at accept time:
  - Error if size=word and addr[0]=1.
  - Error if word address >= DEPTH.
  - An error request goes straight to RESP with resp_err=1 and no memory access.
- FSM states: IDLE, READ, RMW_READ, WRITE, RESP.
  - IDLE: req_ready=1. Accepted request goes to: load -> READ; word store -> WRITE; byte store -> RMW_READ; error -> RESP.
  - READ: capture mem_read_data. Extract the word, or the selected byte extended per req_signed, into resp_rdata. -> RESP.
  - RMW_READ: capture mem_read_data, replace the selected byte with wdata[7:0], hold the merged word in mem_write_data. -> WRITE.
  - WRITE: mem_write=1 for exactly this one cycle. mem_write_data = wdata (word store) or the merged word. -> RESP.
  - RESP: resp_valid=1, with resp_rdata and resp_err stable until resp_ready. On resp_valid & resp_ready -> IDLE.
- req_ready=0 in every state except IDLE; there is no accept in the same cycle as a response handshake.
- mem_address holds the latched word address from accept until the next accept. It is never driven by unlatched req_addr.
- mem_write is a combinational decode of state==WRITE; it is 0 in every other state, including during rst.
- Latency, counted from the accept edge to resp_valid: load 2 cycles, word store 2, byte store 3, error 1.
- resp_valid stays high indefinitely under backpressure (resp_ready=0), and no new request is accepted while it does.
- Reset mid-operation returns to IDLE at the reset edge. A reset asserted during WRITE does not cancel that write, because memory samples mem_write at the same edge. Any pending response is dropped.
- No overlapping or outstanding requests: at most one request in flight.

Decomposition:
- Shared package holds:
  - FSM state enum
  - size encodings SIZE_WORD=0, SIZE_BYTE=1
  - BYTES_PER_WORD=2
- One natural sub-module, lsu_byte_lane: purely combinational extract/extend (load path) and merge (store path), keyed on lane select. The FSM stays in load_store_unit.

Test Plan:
- Word store addr=0x0010, wdata=0xBEEF, then word load addr=0x0010 -> mem_write high exactly one cycle with mem_address=0x0008; load resp_rdata=0xBEEF, resp_err=0, resp_valid 2 cycles after accept.
- Preload word 0x0008 = 0x1234; byte store addr=0x0011, wdata=0x00AB -> RMW_READ then WRITE with mem_write_data=0xAB34; resp 3 cycles after accept; word load then returns 0xAB34.
- Memory word = 0x80F0; byte load addr[0]=0 signed -> 0xFFF0; unsigned -> 0x00F0; addr[0]=1 signed -> 0xFF80.
- Word load addr=0x0003 -> resp_err=1, resp_rdata=0, mem_write never asserted, resp 1 cycle after accept. Word store addr=0x0800 (word 1024) -> resp_err=1, no write.
- Hold resp_ready=0 for 5 cycles with req_valid=1 -> resp_valid and data stable, req_ready=0 throughout; next request accepted the cycle after the response handshake.
- Assert rst during RMW_READ of a byte store -> next cycle IDLE, all outputs at reset values, mem_write never asserted, target memory word unchanged.
